layer_featuremap_accum: RTL and testbench
=========================================

LAYER_FEATUREMAP_ACCUM -- requirements
Module: layer_featuremap_accum

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one channel sample and of data_out, signed two's-complement fixed point.
REQ-002 SHALL have parameter FRAC_BITS, default 16: fractional bits of every sample, BIAS and data_out.
REQ-003 SHALL have parameter NUM_CH, default 32, legal 1..64: number of input channels summed per pixel.
REQ-004 SHALL have parameter IMG_SIZE, default 104: output featuremap side; one frame is IMG_SIZE*IMG_SIZE output pixels.
REQ-005 SHALL have parameter BIAS, default 0, DATA_WIDTH bits: signed bias added to the channel sum.
REQ-006 SHALL have parameter ACT_MODE, default 1: 0 linear, 1 leaky ReLU (slope 1/8), 2 ReLU.
REQ-007 SHALL have port Clk, input, 1: single clock; all state on rising edge.
REQ-008 SHALL have port Rst, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port data_in, input, NUM_CH*DATA_WIDTH: channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port valid_in, input, 1: data_in holds one pixel's channel samples this cycle.
REQ-011 SHALL have port data_out, output, DATA_WIDTH: activated, saturated pixel result.
REQ-012 SHALL have port valid_out, output, 1: data_out valid this cycle.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse on the last pixel of a frame.

Function
REQ-014 SHALL sum all NUM_CH channels in a registered binary adder tree of T = ceil(log2(NUM_CH)) stages (T=0 when NUM_CH=1); missing leaves for non-power-of-two NUM_CH are zero.
REQ-015 SHALL sign-extend each tree level by one bit so internal width is DATA_WIDTH+T+1 with no internal overflow.
REQ-016 SHALL add BIAS (sign-extended) in one registered stage after the tree.
REQ-017 SHALL apply activation and saturation in one final registered stage: mode 0 pass; mode 1 negative values arithmetic-shift-right by 3 (round toward negative infinity); mode 2 negative values become 0.
REQ-018 SHALL saturate after activation to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; no wrap.
REQ-019 SHALL have fixed latency L = T+2 cycles from valid_in to valid_out (L=7 at NUM_CH=32, L=2 at NUM_CH=1).
REQ-020 SHALL accept valid_in every cycle; no backpressure; bubbles propagate as valid_out=0 at the same positions.
REQ-021 SHALL carry valid through a shift register parallel to data; data_out is don't-care but registered-stable when valid_out=0.
REQ-022 SHALL count output pixels (counter width ceil(log2(IMG_SIZE*IMG_SIZE))) on each valid_out=1.
REQ-023 SHALL assert frame_done in the same cycle as the valid_out of pixel index IMG_SIZE*IMG_SIZE-1, then wrap counter to 0 in the next cycle.
REQ-024 SHALL keep frame_done low whenever valid_out is low.
REQ-025 SHALL start the next frame with no idle cycle when valid_in continues back-to-back across a frame boundary.

Reset
REQ-026 SHALL, while Rst=0, drive data_out=0, valid_out=0, frame_done=0 and clear all pipeline, valid and counter registers immediately.
REQ-027 SHALL discard in-flight pixels on reset mid-frame; after release, the first output is counter index 0 and appears L cycles after the first post-reset valid_in.
REQ-028 SHALL ignore valid_in during the cycle Rst deasserts only if it coincides with reset still low at the clock edge.

Verification
REQ-029 NUM_CH=32, FRAC_BITS=16, BIAS=0, ACT_MODE=0, all channels 0x00010000 (1.0), one valid_in -> valid_out exactly 7 cycles later, data_out=0x00200000 (32.0).
REQ-030 ACT_MODE=1, channel sum -8.0 (ch0=0xFFF80000, rest 0), BIAS=0 -> data_out=0xFFFF0000 (-1.0); ACT_MODE=2 same input -> 0x00000000.
REQ-031 All channels 0x7FFFFFFF, BIAS=0x7FFFFFFF, ACT_MODE=0 -> data_out=0x7FFFFFFF; all 0x80000000 -> 0x80000000.
REQ-032 IMG_SIZE=4, 16 back-to-back valids then 16 more -> frame_done pulses on output 16 and 32 only, each single-cycle with valid_out=1.
REQ-033 Alternating valid_in 1/0 pattern -> identical pattern on valid_out shifted by L, values match reference model.
REQ-034 Rst low for 1 cycle after pixel 5 of a frame with 3 pixels in flight -> no output for in-flight pixels, counter restarts, frame_done after next 16 pixels (IMG_SIZE=4).

Source files
------------

// File: rtl/layer_featuremap_accum.sv
// Per-pixel channel accumulator: registered adder tree over NUM_CH samples, bias add,
// activation with saturation, and an output-pixel counter that flags the last pixel of a frame.
module layer_featuremap_accum #(
    parameter int                            DATA_WIDTH = 32,
    parameter int                            FRAC_BITS  = 16,
    parameter int                            NUM_CH     = 32,
    parameter int                            IMG_SIZE   = 104,
    parameter logic signed [DATA_WIDTH-1:0]  BIAS       = '0,
    parameter int                            ACT_MODE   = 1
) (
    input  logic                           Clk,
    input  logic                           Rst,
    // valid_in/valid_out are qualifiers only: a pixel is taken on every cycle valid_in=1
    // (no ready, no stall) and appears exactly T+2 cycles later with valid_out=1.
    input  logic [NUM_CH*DATA_WIDTH-1:0]   data_in,
    input  logic                           valid_in,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           valid_out,
    output logic                           frame_done
);

    localparam int T      = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;
    localparam int LEAVES = 1 << T;
    localparam int IW     = DATA_WIDTH + T + 1;
    localparam int BW     = IW + 1;
    localparam int L      = T + 2;
    localparam int PIX    = IMG_SIZE * IMG_SIZE;
    localparam int CW     = (PIX > 1) ? $clog2(PIX) : 1;
    localparam logic signed [BW-1:0] BIAS_EXT = BW'(BIAS);

    if (NUM_CH < 1 || NUM_CH > 64 || FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH ||
        ACT_MODE < 0 || ACT_MODE > 2) begin : g_param_check
        $error("layer_featuremap_accum: illegal parameter combination");
    end

    // Leaves beyond NUM_CH read the zero padding, so they contribute nothing to the sum.
    logic [LEAVES*DATA_WIDTH-1:0] padded;
    logic signed [IW-1:0]         leaf [LEAVES];
    logic signed [IW-1:0]         tree_sum;

    assign padded = (LEAVES*DATA_WIDTH)'(data_in);

    always_comb begin
        for (int k = 0; k < LEAVES; k++) begin
            leaf[k] = {{(T+1){padded[k*DATA_WIDTH+DATA_WIDTH-1]}},
                       padded[k*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

    if (T == 0) begin : g_no_tree
        assign tree_sum = leaf[0];
    end else begin : g_tree
        logic signed [IW-1:0] lvl [T][LEAVES/2];

        always_ff @(posedge Clk or negedge Rst) begin
            if (!Rst) begin
                for (int l = 0; l < T; l++) begin
                    for (int i = 0; i < LEAVES/2; i++) begin
                        lvl[l][i] <= '0;
                    end
                end
            end else begin
                for (int l = 0; l < T; l++) begin
                    for (int i = 0; i < (LEAVES >> (l+1)); i++) begin
                        if (l == 0) begin
                            lvl[0][i] <= leaf[2*i] + leaf[2*i+1];
                        end else begin
                            lvl[l][i] <= lvl[l-1][2*i] + lvl[l-1][2*i+1];
                        end
                    end
                end
            end
        end

        assign tree_sum = lvl[T-1][0];
    end

    logic signed [BW-1:0]   biased;
    logic signed [BW-1:0]   act;
    logic [DATA_WIDTH-1:0]  sat;
    logic [L-1:0]           vld_sr;
    logic [CW-1:0]          pix_cnt;
    logic                   last_pix;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            biased <= '0;
        end else begin
            biased <= BW'(tree_sum) + BIAS_EXT;
        end
    end

    // Leaky slope is 1/8 via arithmetic shift, which floors toward negative infinity.
    always_comb begin
        act = biased;
        if (biased[BW-1]) begin
            if (ACT_MODE == 1) begin
                act = biased >>> 3;
            end else if (ACT_MODE == 2) begin
                act = '0;
            end
        end
    end

    always_comb begin
        if (act[BW-1:DATA_WIDTH-1] == '0 || act[BW-1:DATA_WIDTH-1] == '1) begin
            sat = act[DATA_WIDTH-1:0];
        end else if (act[BW-1]) begin
            sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            data_out <= '0;
            vld_sr   <= '0;
        end else begin
            data_out <= sat;
            vld_sr   <= {vld_sr[L-2:0], valid_in};
        end
    end

    assign valid_out  = vld_sr[L-1];
    assign last_pix   = (pix_cnt == CW'(PIX - 1));
    assign frame_done = valid_out && last_pix;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pix_cnt <= '0;
        end else if (valid_out) begin
            pix_cnt <= last_pix ? '0 : pix_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_layer_featuremap_accum.sv
// Scoreboard bench: five differently parameterised accumulators share one stimulus stream;
// an arithmetic reference model fills per-instance expected queues drained by a monitor.
module tb_layer_featuremap_accum;

  localparam int NI = 5;
  localparam int DW = 32;
  localparam int BUSW = 32 * DW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            valid_in = 1'b0;
  logic [BUSW-1:0] din = '0;
  logic [NI-1:0]   vo;
  logic [NI-1:0]   fd;
  logic [DW-1:0]   dout [NI];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  int     nch    [NI] = '{32, 32, 32, 3, 1};
  longint bias_v [NI] = '{0, 0, 64'sd2147483647, -64'sd98304, 64'sd65536};
  int     mode   [NI] = '{1, 0, 0, 2, 1};
  int     pix    [NI] = '{16, 16, 16, 9, 4};
  int     lat    [NI] = '{7, 7, 7, 4, 2};
  int     out_idx [NI];

  // entry = {expected output cycle, frame_done, data}
  logic [64:0] exp_q [NI][$];
  logic [64:0] mon_e;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  layer_featuremap_accum #(.DATA_WIDTH(32), .FRAC_BITS(16), .NUM_CH(32), .IMG_SIZE(4),
    .BIAS(32'h00000000), .ACT_MODE(1)) u_a (
    .Clk(clk), .Rst(rst_n), .data_in(din), .valid_in(valid_in),
    .data_out(dout[0]), .valid_out(vo[0]), .frame_done(fd[0]));

  layer_featuremap_accum #(.DATA_WIDTH(32), .FRAC_BITS(16), .NUM_CH(32), .IMG_SIZE(4),
    .BIAS(32'h00000000), .ACT_MODE(0)) u_b (
    .Clk(clk), .Rst(rst_n), .data_in(din), .valid_in(valid_in),
    .data_out(dout[1]), .valid_out(vo[1]), .frame_done(fd[1]));

  layer_featuremap_accum #(.DATA_WIDTH(32), .FRAC_BITS(16), .NUM_CH(32), .IMG_SIZE(4),
    .BIAS(32'h7FFFFFFF), .ACT_MODE(0)) u_c (
    .Clk(clk), .Rst(rst_n), .data_in(din), .valid_in(valid_in),
    .data_out(dout[2]), .valid_out(vo[2]), .frame_done(fd[2]));

  layer_featuremap_accum #(.DATA_WIDTH(32), .FRAC_BITS(16), .NUM_CH(3), .IMG_SIZE(3),
    .BIAS(32'hFFFE8000), .ACT_MODE(2)) u_d (
    .Clk(clk), .Rst(rst_n), .data_in(din[3*DW-1:0]), .valid_in(valid_in),
    .data_out(dout[3]), .valid_out(vo[3]), .frame_done(fd[3]));

  layer_featuremap_accum #(.DATA_WIDTH(32), .FRAC_BITS(16), .NUM_CH(1), .IMG_SIZE(2),
    .BIAS(32'h00010000), .ACT_MODE(1)) u_e (
    .Clk(clk), .Rst(rst_n), .data_in(din[DW-1:0]), .valid_in(valid_in),
    .data_out(dout[4]), .valid_out(vo[4]), .frame_done(fd[4]));

  // reference model: exact sum, bias, activation, clamp
  function automatic logic [31:0] model(input int id, input logic [BUSW-1:0] d);
    longint s;
    s = 0;
    for (int k = 0; k < nch[id]; k++) s += longint'($signed(d[k*DW +: DW]));
    s += bias_v[id];
    if (s < 0 && mode[id] == 1) s = -((-s + 7) / 8);
    if (s < 0 && mode[id] == 2) s = 0;
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s[31:0];
  endfunction

  function automatic logic [BUSW-1:0] rand_px();
    logic [BUSW-1:0] d;
    bit full;
    full = ($urandom_range(0, 3) == 0);
    for (int k = 0; k < 32; k++) begin
      if (full) d[k*DW +: DW] = $urandom();
      else d[k*DW +: DW] = 32'($urandom_range(0, 2**21)) - 32'h0010_0000;
    end
    return d;
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic [BUSW-1:0] d);
    int ce;
    bit f;
    @(posedge clk);
    #1;
    valid_in = v;
    din = d;
    if (v) begin
      for (int id = 0; id < NI; id++) begin
        ce = cyc + lat[id];
        f = ((out_idx[id] % pix[id]) == pix[id] - 1);
        out_idx[id]++;
        exp_q[id].push_back({ce[31:0], f, model(id, d)});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, rand_px());
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    valid_in = 1'b0;
    for (int id = 0; id < NI; id++) begin
      exp_q[id].delete();
      out_idx[id] = 0;
    end
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    for (int id = 0; id < NI; id++) begin
      if (!rst_n) begin
        vectors++;
        if (vo[id] || fd[id] || dout[id] != '0) begin
          miscompares++;
          $display("FAIL reset_state inst%0d: got valid_out=%b frame_done=%b data_out=%h, need 0 0 00000000",
                   id, vo[id], fd[id], dout[id]);
        end
      end else if (vo[id]) begin
        vectors++;
        if (exp_q[id].size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output inst%0d cycle %0d: got data_out=%h, nothing expected",
                   id, cyc, dout[id]);
        end else begin
          mon_e = exp_q[id].pop_front();
          if (dout[id] != mon_e[31:0] || fd[id] != mon_e[32] || cyc != int'(mon_e[64:33])) begin
            miscompares++;
            $display("FAIL pixel inst%0d: got data=%h frame_done=%b cycle=%0d, need data=%h frame_done=%b cycle=%0d",
                     id, dout[id], fd[id], cyc, mon_e[31:0], mon_e[32], mon_e[64:33]);
          end
        end
      end else begin
        vectors++;
        if (fd[id]) begin
          miscompares++;
          $display("FAIL frame_done_idle inst%0d cycle %0d: got frame_done=1 with valid_out=0, need 0", id, cyc);
        end
      end
    end
  end

  initial begin
    logic [BUSW-1:0] d;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // all channels 1.0
    drive(1'b1, {32{32'h00010000}});
    idle(10);

    // channel sum -8.0
    d = '0;
    d[31:0] = 32'hFFF80000;
    drive(1'b1, d);
    idle(10);

    // saturation extremes
    drive(1'b1, {32{32'h7FFFFFFF}});
    drive(1'b1, {32{32'h80000000}});
    idle(10);

    // two back-to-back frames from a fresh counter
    do_reset(1);
    for (int i = 0; i < 32; i++) drive(1'b1, rand_px());
    idle(10);

    // alternating valid pattern
    for (int i = 0; i < 24; i++) drive((i % 2) == 0, rand_px());
    idle(10);

    // reset mid-frame with pixels in flight, then a full frame
    do_reset(1);
    for (int i = 0; i < 5; i++) drive(1'b1, rand_px());
    idle(8);
    for (int i = 0; i < 3; i++) drive(1'b1, rand_px());
    do_reset(1);
    for (int i = 0; i < 16; i++) drive(1'b1, rand_px());
    idle(10);

    // randomized traffic with bubbles
    for (int i = 0; i < 80; i++) drive($urandom_range(0, 3) != 0, rand_px());
    idle(12);

    for (int id = 0; id < NI; id++) begin
      vectors++;
      if (exp_q[id].size() != 0) begin
        miscompares++;
        $display("FAIL drain inst%0d: got %0d outputs still pending, need 0", id, exp_q[id].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
